// File: rtl/cluster_stats_if.sv
// Record stream from cluster_stats to the centroid/output stage.
// Master drives one record per non-empty cluster; slave returns out_ready.
interface cluster_stats_if #(
    parameter int AW = 4,
    parameter int LW = 4,
    parameter int CW = 8
);
    logic              out_valid;
    logic              out_ready;
    logic [LW-1:0]     out_label;
    logic [AW:0]       out_count;
    logic [CW+AW-1:0]  out_sum_x;
    logic [CW+AW-1:0]  out_sum_y;
    logic [CW+AW-1:0]  out_sum_z;

    modport master (
        output out_valid, out_label, out_count, out_sum_x, out_sum_y, out_sum_z,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_label, out_count, out_sum_x, out_sum_y, out_sum_z,
        output out_ready
    );
endinterface

// File: rtl/cluster_stats.sv
// Per-cluster point count and xyz sums; done 1+N+1+(2^LW-1)+E+1 cycles after start accept.
// Record fields hold while out_valid=1 and out_ready=0; the label scan stalls until transfer.
module cluster_stats #(
    parameter int N  = 16,
    parameter int AW = 4,
    parameter int LW = 4,
    parameter int CW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [AW-1:0]     raddr,
    input  logic [LW-1:0]     rlabel,
    input  logic [CW-1:0]     rx,
    input  logic [CW-1:0]     ry,
    input  logic [CW-1:0]     rz,
    cluster_stats_if.master   rec,
    output logic [LW-1:0]     num_clusters,
    output logic [AW:0]       noise_count,
    output logic              busy,
    output logic              done
);
    localparam int              NL        = (1 << LW) - 1;
    localparam logic [AW-1:0]   LAST_ADDR = AW'(N - 1);
    localparam logic [LW-1:0]   LAST_LBL  = LW'(NL);

    typedef enum logic [2:0] {IDLE, CLEAR, READ, DRAIN, EMIT, FIN} state_t;

    state_t state, state_nxt;

    logic [AW:0]      cnt [1:NL];
    logic [CW+AW-1:0] sx  [1:NL];
    logic [CW+AW-1:0] sy  [1:NL];
    logic [CW+AW-1:0] sz  [1:NL];
    logic [LW-1:0]    p;

    logic clr, acc_en, load, xfer, p_adv;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        acc_en    = 1'b0;
        load      = 1'b0;
        xfer      = 1'b0;
        p_adv     = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = CLEAR;
            CLEAR: begin
                clr       = 1'b1;
                state_nxt = READ;
            end
            READ: begin
                // Memory data lags the address by one cycle; raddr=0 has nothing to retire yet.
                acc_en = (raddr != '0);
                if (raddr == LAST_ADDR) state_nxt = DRAIN;
            end
            DRAIN: begin
                acc_en    = 1'b1;
                state_nxt = EMIT;
            end
            EMIT: begin
                if (!rec.out_valid) begin
                    if (cnt[p] == '0) p_adv = 1'b1;
                    else              load  = 1'b1;
                end else if (rec.out_ready) begin
                    xfer  = 1'b1;
                    p_adv = 1'b1;
                end
                if (p_adv && p == LAST_LBL) state_nxt = FIN;
            end
            FIN:     if (done && !start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= NL; i++) begin
                cnt[i] <= '0;
                sx[i]  <= '0;
                sy[i]  <= '0;
                sz[i]  <= '0;
            end
            raddr         <= '0;
            p             <= LW'(1);
            num_clusters  <= '0;
            noise_count   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            rec.out_valid <= 1'b0;
            rec.out_label <= '0;
            rec.out_count <= '0;
            rec.out_sum_x <= '0;
            rec.out_sum_y <= '0;
            rec.out_sum_z <= '0;
        end else begin
            if (state == IDLE && start) busy <= 1'b1;

            if (clr) begin
                for (int i = 1; i <= NL; i++) begin
                    cnt[i] <= '0;
                    sx[i]  <= '0;
                    sy[i]  <= '0;
                    sz[i]  <= '0;
                end
                num_clusters <= '0;
                noise_count  <= '0;
                raddr        <= '0;
            end

            if (state == READ && raddr != LAST_ADDR) raddr <= raddr + AW'(1);

            // Each entry is read and written from flops every cycle, so repeated labels need no bypass.
            if (acc_en) begin
                if (rlabel != '0) begin
                    cnt[rlabel] <= cnt[rlabel] + (AW+1)'(1);
                    sx[rlabel]  <= sx[rlabel] + (CW+AW)'(rx);
                    sy[rlabel]  <= sy[rlabel] + (CW+AW)'(ry);
                    sz[rlabel]  <= sz[rlabel] + (CW+AW)'(rz);
                end else begin
                    noise_count <= noise_count + (AW+1)'(1);
                end
            end

            if (state == DRAIN) p <= LW'(1);
            if (p_adv)          p <= p + LW'(1);

            if (load) begin
                rec.out_valid <= 1'b1;
                rec.out_label <= p;
                rec.out_count <= cnt[p];
                rec.out_sum_x <= sx[p];
                rec.out_sum_y <= sy[p];
                rec.out_sum_z <= sz[p];
                num_clusters  <= num_clusters + LW'(1);
            end
            if (xfer) rec.out_valid <= 1'b0;

            if (state == FIN) begin
                if (!done) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end else if (!start) begin
                    done <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cluster_stats.sv
// Scoreboard bench for cluster_stats: a behavioural memory feeds points, expected records
// are computed from the memory contents at load time and matched against transferred records.
module tb_cluster_stats;
    localparam int N  = 16;
    localparam int AW = 4;
    localparam int LW = 4;
    localparam int CW = 8;
    localparam int NL = (1 << LW) - 1;

    typedef struct packed {
        logic [LW-1:0]    label;
        logic [AW:0]      count;
        logic [CW+AW-1:0] sx;
        logic [CW+AW-1:0] sy;
        logic [CW+AW-1:0] sz;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AW-1:0]    raddr;
    logic [LW-1:0]    rlabel;
    logic [CW-1:0]    rx, ry, rz;
    logic [LW-1:0]    num_clusters;
    logic [AW:0]      noise_count;
    logic             busy, done;

    cluster_stats_if #(.AW(AW), .LW(LW), .CW(CW)) rec ();

    cluster_stats #(.N(N), .AW(AW), .LW(LW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .raddr(raddr),
        .rlabel(rlabel), .rx(rx), .ry(ry), .rz(rz), .rec(rec),
        .num_clusters(num_clusters), .noise_count(noise_count),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [LW-1:0] mem_l [N];
    logic [CW-1:0] mem_x [N];
    logic [CW-1:0] mem_y [N];
    logic [CW-1:0] mem_z [N];

    always @(posedge clk) begin
        rlabel <= mem_l[raddr];
        rx     <= mem_x[raddr];
        ry     <= mem_y[raddr];
        rz     <= mem_z[raddr];
    end

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   exp_noise, exp_e;
    int   errors = 0;
    int   checks = 0;

    task automatic load_data(input int kind);
        rec_t r;
        int   c, ax, ay, az;
        for (int k = 0; k < N; k++) begin
            case (kind)
                0: begin mem_l[k] = '0; mem_x[k] = CW'(k); mem_y[k] = CW'(k); mem_z[k] = CW'(k); end
                1: begin mem_l[k] = (k < 8) ? LW'(1) : LW'(2); mem_x[k] = CW'(k); mem_y[k] = CW'(2*k); mem_z[k] = '0; end
                2: begin mem_l[k] = (k == 0) ? LW'(3) : LW'(15); mem_x[k] = 8'd255; mem_y[k] = CW'(k); mem_z[k] = 8'd1; end
                default: begin mem_l[k] = LW'(k % 4); mem_x[k] = CW'(k); mem_y[k] = CW'(k+1); mem_z[k] = CW'(3*k); end
            endcase
        end
        exp_q.delete();
        exp_noise = 0;
        exp_e     = 0;
        for (int k = 0; k < N; k++) if (mem_l[k] == 0) exp_noise++;
        for (int l = 1; l <= NL; l++) begin
            c = 0; ax = 0; ay = 0; az = 0;
            for (int k = 0; k < N; k++) begin
                if (int'(mem_l[k]) == l) begin
                    c++; ax += int'(mem_x[k]); ay += int'(mem_y[k]); az += int'(mem_z[k]);
                end
            end
            if (c > 0) begin
                r.label = LW'(l); r.count = (AW+1)'(c);
                r.sx = (CW+AW)'(ax); r.sy = (CW+AW)'(ay); r.sz = (CW+AW)'(az);
                exp_q.push_back(r);
                exp_e++;
            end
        end
    endtask

    // Called just after a falling edge with the DUT idle; the next rising edge accepts start.
    // done_k counts falling edges after the accept edge (0 = first one) until done is seen.
    task automatic run_capture(input int stall, input bit pulse,
                               output int done_k, output bit timeout, output bit stable);
        rec_t cur, held;
        bit   first_seen = 1'b0;
        int   stall_left = stall;
        obs_q.delete();
        stable  = 1'b1;
        timeout = 1'b1;
        done_k  = -1;
        start   = 1'b1;
        rec.out_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (pulse) start = 1'b0;
            if (done === 1'b1) begin
                done_k  = k;
                timeout = 1'b0;
                break;
            end
            cur = {rec.out_label, rec.out_count, rec.out_sum_x, rec.out_sum_y, rec.out_sum_z};
            if (rec.out_valid === 1'b1) begin
                if (!first_seen) begin
                    first_seen = 1'b1;
                    held = cur;
                end
                if (obs_q.size() == 0 && stall > 0 && cur !== held) stable = 1'b0;
                if (stall_left > 0) begin
                    rec.out_ready = 1'b0;
                    stall_left--;
                end else begin
                    rec.out_ready = 1'b1;
                    obs_q.push_back(cur);
                end
            end else if (first_seen && obs_q.size() == 0) begin
                stable = 1'b0;
            end
        end
        rec.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rec.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (rec.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", rec.out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (raddr !== '0) begin errors++; $display("FAIL reset_raddr got=%0d want=0", raddr); end
        checks++; if (num_clusters !== '0) begin errors++; $display("FAIL reset_nclus got=%0d want=0", num_clusters); end
        checks++; if (noise_count !== '0) begin errors++; $display("FAIL reset_noise got=%0d want=0", noise_count); end
    endtask

    task automatic test_all_noise();
        int dk; bit to, st;
        load_data(0);
        run_capture(0, 1'b1, dk, to, st);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL noise_timeout got=timeout want=done"); end
        checks++; if (dk != 34) begin errors++; $display("FAIL noise_latency got=%0d want=34", dk); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL noise_records got=%0d want=0", obs_q.size()); end
        checks++; if (noise_count !== 5'd16) begin errors++; $display("FAIL noise_count got=%0d want=16", noise_count); end
        checks++; if (num_clusters !== '0) begin errors++; $display("FAIL noise_nclus got=%0d want=0", num_clusters); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noise_busy got=%b want=0", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL noise_done_clear got=%b want=0", done); end
    endtask

    task automatic test_two_clusters();
        int dk; bit to, st; rec_t e, o;
        load_data(1);
        run_capture(0, 1'b1, dk, to, st);
        checks++; if (to !== 1'b0 || dk != 34 + exp_e) begin errors++; $display("FAIL two_latency got=%0d want=%0d", dk, 34 + exp_e); end
        checks++; if (num_clusters !== 4'd2) begin errors++; $display("FAIL two_nclus got=%0d want=2", num_clusters); end
        checks++; if (noise_count !== 5'(exp_noise)) begin errors++; $display("FAIL two_noise got=%0d want=%0d", noise_count, exp_noise); end
        if (obs_q.size() == 2) begin
            checks++; if (obs_q[0].count !== 5'd8 || obs_q[0].sx !== 12'd28 || obs_q[0].sy !== 12'd56 || obs_q[0].sz !== 12'd0)
                begin errors++; $display("FAIL two_rec1 got=%0d/%0d/%0d/%0d want=8/28/56/0", obs_q[0].count, obs_q[0].sx, obs_q[0].sy, obs_q[0].sz); end
            checks++; if (obs_q[1].count !== 5'd8 || obs_q[1].sx !== 12'd92 || obs_q[1].sy !== 12'd184)
                begin errors++; $display("FAIL two_rec2 got=%0d/%0d/%0d want=8/92/184", obs_q[1].count, obs_q[1].sx, obs_q[1].sy); end
        end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL two_nrec got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL two_record got=%h want=%h", o, e); end
        end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL two_done_clear got=%b want=0", done); end
    endtask

    task automatic test_backpressure();
        int dk; bit to, st; rec_t e, o;
        load_data(1);
        run_capture(5, 1'b1, dk, to, st);
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL stall_stable got=unstable want=stable"); end
        checks++; if (to !== 1'b0 || dk != 34 + exp_e + 5) begin errors++; $display("FAIL stall_latency got=%0d want=%0d", dk, 39 + exp_e); end
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL stall_nrec got=%0d want=2", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL stall_record got=%h want=%h", o, e); end
        end
        @(negedge clk);
    endtask

    task automatic test_sparse_labels();
        int dk; bit to, st; rec_t e, o;
        load_data(2);
        run_capture(0, 1'b1, dk, to, st);
        checks++; if (to !== 1'b0 || dk != 36) begin errors++; $display("FAIL sparse_latency got=%0d want=36", dk); end
        if (obs_q.size() == 2) begin
            checks++; if (obs_q[0].label !== 4'd3 || obs_q[0].count !== 5'd1 || obs_q[0].sx !== 12'd255)
                begin errors++; $display("FAIL sparse_rec3 got=%0d/%0d/%0d want=3/1/255", obs_q[0].label, obs_q[0].count, obs_q[0].sx); end
            checks++; if (obs_q[1].label !== 4'd15 || obs_q[1].count !== 5'd15 || obs_q[1].sx !== 12'd3825)
                begin errors++; $display("FAIL sparse_rec15 got=%0d/%0d/%0d want=15/15/3825", obs_q[1].label, obs_q[1].count, obs_q[1].sx); end
        end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL sparse_nrec got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL sparse_record got=%h want=%h", o, e); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        int dk; bit to, st, hit; rec_t e, o;
        load_data(3);
        hit = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy === 1'b1 && raddr === 4'd7) begin hit = 1'b1; break; end
        end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL midread_reach got=timeout want=raddr7"); end
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || rec.out_valid !== 1'b0 || raddr !== '0)
            begin errors++; $display("FAIL midread_ctrl got=busy%b done%b vld%b raddr%0d want=all0", busy, done, rec.out_valid, raddr); end
        checks++; if (noise_count !== '0 || num_clusters !== '0)
            begin errors++; $display("FAIL midread_counts got=%0d/%0d want=0/0", noise_count, num_clusters); end
        checks++; if (rec.out_label !== '0 || rec.out_count !== '0 || rec.out_sum_x !== '0 || rec.out_sum_y !== '0 || rec.out_sum_z !== '0)
            begin errors++; $display("FAIL midread_fields got=%0d/%0d/%0d want=0", rec.out_label, rec.out_count, rec.out_sum_x); end
        run_capture(0, 1'b1, dk, to, st);
        checks++; if (to !== 1'b0 || dk != 34 + exp_e) begin errors++; $display("FAIL midread_latency got=%0d want=%0d", dk, 34 + exp_e); end
        checks++; if (noise_count !== 5'(exp_noise)) begin errors++; $display("FAIL midread_noise got=%0d want=%0d", noise_count, exp_noise); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL midread_nrec got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL midread_record got=%h want=%h", o, e); end
        end
        @(negedge clk);
    endtask

    task automatic test_start_held();
        int dk, bad; bit to, st; rec_t e, o;
        load_data(1);
        run_capture(0, 1'b0, dk, to, st);
        checks++; if (to !== 1'b0 || dk != 34 + exp_e) begin errors++; $display("FAIL held_latency got=%0d want=%0d", dk, 34 + exp_e); end
        exp_q.delete();
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (done !== 1'b1 || busy !== 1'b0 || rec.out_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL held_no_retrigger got=%0d bad cycles want=0", bad); end
        start = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL held_done_clear got=%b want=0", done); end
        load_data(1);
        run_capture(0, 1'b1, dk, to, st);
        checks++; if (to !== 1'b0 || dk != 34 + exp_e) begin errors++; $display("FAIL rerun_latency got=%0d want=%0d", dk, 34 + exp_e); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rerun_nrec got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL rerun_record got=%h want=%h", o, e); end
        end
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=no finish want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_all_noise();
        test_two_clusters();
        test_backpressure();
        test_sparse_labels();
        test_reset_mid_read();
        test_start_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cluster_stats.md
Name: cluster_stats

Overview:
Downstream consumer of the clustering FSM. Once clustering reports done, this block reads the label memory and the point-coordinate memory. For every point it accumulates the point count and the per-axis coordinate sums of its cluster. It then streams one record per non-empty cluster over a valid/ready interface to the centroid/output stage. Label 0 means an unclustered (noise) point and is counted separately.

Parameters:
N, 16, number of points in the cloud
AW, 4, point address width (2^AW >= N)
LW, 4, label width; legal cluster labels are 1..2^LW-1
CW, 8, unsigned coordinate width per axis

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  level; normally wired to the clustering FSM done
raddr  output  AW  read address to the label and point memories
rlabel  input  LW  label of point raddr, valid 1 cycle after raddr
rx  input  CW  x coordinate of point raddr, 1-cycle read latency
ry  input  CW  y coordinate, 1-cycle read latency
rz  input  CW  z coordinate, 1-cycle read latency
out_valid  output  1  record valid
out_ready  input  1  downstream accepts record
out_label  output  LW  cluster label of record
out_count  output  AW+1  points in cluster
out_sum_x  output  CW+AW  sum of x over cluster
out_sum_y  output  CW+AW  sum of y
out_sum_z  output  CW+AW  sum of z
num_clusters  output  LW  count of non-empty clusters; final when done=1
noise_count  output  AW+1  points with label 0; final when done=1
busy  output  1  high from start accept until done
done  output  1  results complete

Behaviour:
- Reset (rst=1 at a clk edge) forces state IDLE and clears all outputs and accumulators to 0, from any state. This includes reset mid-READ and mid-EMIT; an in-flight record is dropped.
- Accumulators are flop arrays, one entry per label 1..2^LW-1:
  - cnt: AW+1 bits
  - sx, sy, sz: CW+AW bits each
  - Widths are sized so no overflow is possible; no saturation logic.
- States:
  - IDLE: start=1 -> CLEAR, busy<=1. Otherwise hold.
  - CLEAR, 1 cycle: zero all accumulators, num_clusters and noise_count. raddr<=0 -> READ.
  - READ, N cycles: raddr increments by 1 per cycle, 0..N-1. Data returned for address k-1 is accumulated in the same cycle address k is issued. After raddr=N-1 is issued -> DRAIN.
  - DRAIN, 1 cycle: accumulate data for point N-1. Label pointer p<=1 -> EMIT.
  - EMIT: scans p = 1..2^LW-1.
    - If out_valid=0 and cnt[p]=0: p advances (1 cycle per empty label).
    - If out_valid=0 and cnt[p]!=0: register the record, out_valid<=1, num_clusters+=1.
    - If out_valid=1 and out_ready=1: out_valid<=0, p advances.
    - After the last label is handled -> FIN.
  - FIN: done<=1, busy<=0. Stay until start=0, then -> IDLE with done<=0.
- Accumulation rule per received point: label L!=0 -> cnt[L]+=1, sx[L]+=x, sy[L]+=y, sz[L]+=z; L=0 -> noise_count+=1.
- Back-to-back points with the same label accumulate correctly every cycle (no hazard).
- Handshake rules:
  - While out_valid=1 and out_ready=0, every out_* field holds stable.
  - out_valid never drops without a transfer, except on rst.
- Records are emitted in ascending label order. Empty labels are never emitted.
- start is ignored outside IDLE, so start staying high after done does not retrigger.
- Latency with out_ready held at 1: done rises exactly 1+N+1+(2^LW-1)+E+1 cycles after the start-accept edge, where E = number of non-empty clusters.
- raddr holds N-1 after READ.
- num_clusters and noise_count are final once FIN is reached. noise_count is final after DRAIN.

Test Plan:
- All 16 labels = 0, start pulse -> out_valid never asserts; done=1 with noise_count=16, num_clusters=0; done exactly 34 cycles after the accept edge.
- Points 0-7 label 1, points 8-15 label 2, x=k, y=2k, z=0:
  - record 1: count=8, sum_x=28, sum_y=56, sum_z=0
  - record 2: count=8, sum_x=92, sum_y=184
  - num_clusters=2
- Same data with out_ready=0 for 5 cycles on the first record -> out_valid stays high and fields stay constant for those 5 cycles; exactly 2 records total, in label order.
- Only labels 3 and 15 used (point 0 -> label 3 with x=255, others -> label 15 with x=255) -> two records only:
  - label 3: count=1, sum_x=255
  - label 15: count=15, sum_x=3825
- rst asserted for 1 cycle mid-READ at raddr=7 -> next cycle all outputs 0 and state IDLE; a new start produces results identical to a clean run.
- start held high through FIN -> no second run; drop start for 1 cycle then raise it -> done clears and a full second run repeats identical records.
